mem_port_arbiter: RTL

Two-requester arbiter that shares one single-port synchronous memory between the CPU instruction-fetch port (I) and the load/store port (D). It issues at most one memory access per cycle, arbitrates round-robin on contention, and routes the one-cycle-latency read data back to the requester that issued the read. It sits between `cpu_single_cycle`'s fetch/LSU interfaces and a unified instruction/data memory.

---
 rtl/mem_port_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one synchronous memory between fetch and load/store ports
// Single access per cycle, zero-latency grant, read data steered back to the port that issued the read.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_gnt,
  output logic                    i_rvalid,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    m_req,
  output logic                    m_we,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_be,
  input  logic [DATA_WIDTH-1:0]   m_rdata
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic last_d;
  logic rsp_i;
  logic rsp_d;
  logic i_win;
  logic d_win;

  // Gated by rst_n so no grant can leak out while the block is held in reset.
  always_comb begin
    i_win = 1'b0;
    d_win = 1'b0;
    if (rst_n) begin
      if (i_req && d_req) begin
        i_win = last_d;
        d_win = !last_d;
      end else begin
        i_win = i_req;
        d_win = d_req;
      end
    end
  end

  assign i_gnt = i_win;
  assign d_gnt = d_win;
  assign m_req = i_win | d_win;

  always_comb begin
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_be    = '0;
    if (i_win) begin
      m_addr = i_addr;
      m_be   = {BE_WIDTH{1'b1}};
    end else if (d_win) begin
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_be    = d_be;
    end
  end

  // last_d only moves on a grant; response flags reload every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b0;
      rsp_i  <= 1'b0;
      rsp_d  <= 1'b0;
    end else begin
      if (i_win || d_win) begin
        last_d <= d_win;
      end
      rsp_i <= i_win;
      rsp_d <= d_win & ~d_we;
    end
  end

  assign i_rvalid = rsp_i;
  assign d_rvalid = rsp_d;
  assign i_rdata  = rsp_i ? m_rdata : '0;
  assign d_rdata  = rsp_d ? m_rdata : '0;

endmodule
